// File: rtl/rv_stream_sink.sv
// rv_stream_sink: consumer end of a ready/valid stream.
// Pseudo-random bounded backpressure from an 8-bit Galois LFSR. Keeps the last
// accepted word and a saturating transfer count, with optional DONE after
// EXPECT_COUNT transfers.
// Optional build macro RV_STREAM_SINK_PROTOCOL_CHECK_EN adds a sticky checker
// that flags a stalled word being withdrawn or changed.
module rv_stream_sink #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5,
  parameter int unsigned READY_THRESHOLD = 128,
  parameter int unsigned MAX_STALL       = 7,
  parameter int unsigned EXPECT_COUNT    = 0
) (
  input  logic                 i_CLK,
  input  logic                 i_RSTn,
  input  logic                 i_VALID,
  output logic                 o_READY,
  input  logic [WIDTH-1:0]     i_D,
  output logic [WIDTH-1:0]     o_LAST_D,
  output logic [CNT_WIDTH-1:0] o_COUNT,
  output logic                 o_DONE,
  output logic                 o_ERR
);

  localparam int unsigned LFSR_W  = 8;
  localparam int unsigned STALL_W = 8;
  localparam logic [LFSR_W-1:0]    LFSR_MASK  = 8'hB8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_TARGET = CNT_WIDTH'(EXPECT_COUNT);
  // DONE only exists for a nonzero target the counter can actually reach
  localparam bit DONE_EN = (EXPECT_COUNT != 0) &&
                           ((CNT_WIDTH >= 32) ||
                            (64'(EXPECT_COUNT) <= ((64'(1) << CNT_WIDTH) - 64'(1))));

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [LFSR_W-1:0]    lfsr, lfsr_next;
  logic [STALL_W-1:0]   stall_cnt, stall_next;
  logic [CNT_WIDTH-1:0] count_next;
  logic [WIDTH-1:0]     last_next;
  logic                 ready_next;
  logic                 done_next;
  logic                 xfer;

  assign xfer = i_VALID && o_READY;

  // State and registered outputs
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state     <= ST_WAIT;
      lfsr      <= LFSR_SEED;
      stall_cnt <= '0;
      o_READY   <= 1'b0;
      o_COUNT   <= '0;
      o_LAST_D  <= '0;
      o_DONE    <= 1'b0;
    end else begin
      state     <= state_next;
      lfsr      <= lfsr_next;
      stall_cnt <= stall_next;
      o_READY   <= ready_next;
      o_COUNT   <= count_next;
      o_LAST_D  <= last_next;
      o_DONE    <= done_next;
    end
  end

  // Next state, backpressure decision and transfer bookkeeping
  always_comb begin
    state_next = state;
    lfsr_next  = lfsr;
    stall_next = stall_cnt;
    ready_next = 1'b0;
    count_next = o_COUNT;
    last_next  = o_LAST_D;
    done_next  = o_DONE;

    if (xfer || !i_VALID) begin
      stall_next = '0;
    end else if (stall_cnt != '1) begin
      stall_next = stall_cnt + STALL_W'(1);
    end

    if (xfer) begin
      last_next = i_D;
      if (o_COUNT != CNT_MAX) begin
        count_next = o_COUNT + CNT_WIDTH'(1);
      end
    end

    case (state)
      ST_WAIT: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        lfsr_next = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_MASK : '0);
        if (DONE_EN && xfer && (count_next == CNT_TARGET)) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else begin
          ready_next = (32'(lfsr_next) >= READY_THRESHOLD) ||
                       (32'(stall_next) >= MAX_STALL);
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_WAIT;
      end
    endcase
  end

`ifdef RV_STREAM_SINK_PROTOCOL_CHECK_EN
  logic             prev_stalled;
  logic [WIDTH-1:0] prev_d;
  logic             violation;

  assign violation = (state == ST_RUN) && prev_stalled &&
                     (!i_VALID || (i_D != prev_d));

  // A stalled word must stay offered and unchanged until accepted
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      prev_stalled <= 1'b0;
      prev_d       <= '0;
      o_ERR        <= 1'b0;
    end else begin
      prev_stalled <= i_VALID && !o_READY;
      prev_d       <= i_D;
      if (violation) begin
        o_ERR <= 1'b1;
`ifndef SYNTHESIS
        $display("%0t rv_stream_sink: stalled word withdrawn or changed", $time);
`endif
      end
    end
  end
`else
  assign o_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_rv_stream_sink.sv
// Bench for rv_stream_sink: five differently parameterised sinks share one
// stimulus stream and are checked against a cycle-level reference model.
`timescale 1ns/1ps
module tb_rv_stream_sink;

  localparam int N = 5;
`ifdef RV_STREAM_SINK_PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Per-instance parameters, in instance order
  localparam int P_THR [N] = '{128, 0, 255, 0, 100};
  localparam int P_MS  [N] = '{7, 7, 3, 7, 7};
  localparam int P_EXP [N] = '{0, 0, 0, 4, 0};
  localparam int P_CMAX[N] = '{65535, 65535, 65535, 65535, 7};
  localparam int P_SEED[N] = '{165, 165, 165, 165, 60};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0;
  logic [3:0] d = 4'h0;

  logic [N-1:0]       rdy, dn, er;
  logic [N-1:0][15:0] cnt;
  logic [N-1:0][3:0]  lst;
  logic [2:0]         cnt4;

  assign cnt[4] = {13'd0, cnt4};

  always #5 clk = ~clk;

  rv_stream_sink #(.READY_THRESHOLD(128)) u0 (
    .i_CLK(clk), .i_RSTn(rst_n), .i_VALID(valid), .o_READY(rdy[0]), .i_D(d),
    .o_LAST_D(lst[0]), .o_COUNT(cnt[0]), .o_DONE(dn[0]), .o_ERR(er[0]));
  rv_stream_sink #(.READY_THRESHOLD(0)) u1 (
    .i_CLK(clk), .i_RSTn(rst_n), .i_VALID(valid), .o_READY(rdy[1]), .i_D(d),
    .o_LAST_D(lst[1]), .o_COUNT(cnt[1]), .o_DONE(dn[1]), .o_ERR(er[1]));
  rv_stream_sink #(.READY_THRESHOLD(255), .MAX_STALL(3)) u2 (
    .i_CLK(clk), .i_RSTn(rst_n), .i_VALID(valid), .o_READY(rdy[2]), .i_D(d),
    .o_LAST_D(lst[2]), .o_COUNT(cnt[2]), .o_DONE(dn[2]), .o_ERR(er[2]));
  rv_stream_sink #(.READY_THRESHOLD(0), .EXPECT_COUNT(4)) u3 (
    .i_CLK(clk), .i_RSTn(rst_n), .i_VALID(valid), .o_READY(rdy[3]), .i_D(d),
    .o_LAST_D(lst[3]), .o_COUNT(cnt[3]), .o_DONE(dn[3]), .o_ERR(er[3]));
  rv_stream_sink #(.CNT_WIDTH(3), .READY_THRESHOLD(100), .LFSR_SEED(8'h3C)) u4 (
    .i_CLK(clk), .i_RSTn(rst_n), .i_VALID(valid), .o_READY(rdy[4]), .i_D(d),
    .o_LAST_D(lst[4]), .o_COUNT(cnt4), .o_DONE(dn[4]), .o_ERR(er[4]));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (expected outputs after the most recent edge)
  int m_lfsr[N], m_stall[N], m_cnt[N], m_last[N], m_pd[N];
  bit m_rdy[N], m_done[N], m_err[N], m_run[N], m_pst[N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_lfsr[i] = P_SEED[i]; m_stall[i] = 0; m_cnt[i] = 0; m_last[i] = 0;
      m_pd[i] = 0; m_rdy[i] = 0; m_done[i] = 0; m_err[i] = 0; m_run[i] = 0;
      m_pst[i] = 0;
    end
  endtask

  // One rising edge of every sink given the offered valid/data
  task automatic model_step(input bit v, input logic [3:0] dv);
    for (int i = 0; i < N; i++) begin
      bit x;
      x = v && m_rdy[i];
      if (CHK && m_run[i] && !m_done[i] && m_pst[i] && (!v || int'(dv) != m_pd[i]))
        m_err[i] = 1;
      m_pst[i] = v && !m_rdy[i];
      m_pd[i]  = int'(dv);
      if (x || !v) m_stall[i] = 0;
      else if (m_stall[i] < 255) m_stall[i] = m_stall[i] + 1;
      if (m_done[i]) begin
        m_rdy[i] = 0;
      end else if (!m_run[i]) begin
        m_run[i] = 1;
        m_rdy[i] = 0;
      end else begin
        m_lfsr[i] = (m_lfsr[i] % 2 == 1) ? ((m_lfsr[i] / 2) ^ 184) : (m_lfsr[i] / 2);
        if (x) begin
          if (m_cnt[i] < P_CMAX[i]) m_cnt[i] = m_cnt[i] + 1;
          m_last[i] = int'(dv);
        end
        if (x && P_EXP[i] != 0 && m_cnt[i] == P_EXP[i]) begin
          m_done[i] = 1;
          m_rdy[i]  = 0;
        end else begin
          m_rdy[i] = (m_lfsr[i] >= P_THR[i]) || (m_stall[i] >= P_MS[i]);
        end
      end
    end
  endtask

  // Drive inputs at a falling edge, advance the model, wait for the next falling edge
  task automatic cycle(input bit v, input logic [3:0] dv);
    valid = v;
    d = dv;
    model_step(v, dv);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    d = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b1;
    d = 4'h3;
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if ({rdy[i], cnt[i], lst[i], dn[i], er[i]} !== 23'd0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: rdy=%b cnt=%0d last=%h done=%b err=%b, required all 0",
                 i, rdy[i], cnt[i], lst[i], dn[i], er[i]);
      end
    end
    rst_n = 1'b1;
    cycle(1'b1, 4'h3);
    n_tests++;
    if (rdy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_edge: rdy=%b, required 0", rdy[1]);
    end
    cycle(1'b1, 4'h3);
    n_tests++;
    if (rdy[1] !== 1'b1 || cnt[1] !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_second_edge: rdy=%b cnt=%0d, required rdy=1 cnt=0", rdy[1], cnt[1]);
    end
    cycle(1'b1, 4'h3);
    n_tests++;
    if (cnt[1] !== 16'd1 || lst[1] !== 4'h3) begin
      n_fail++;
      $display("FAIL reset_first_xfer: cnt=%0d last=%h, required cnt=1 last=3", cnt[1], lst[1]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(1'b0, 4'h0);
    cycle(1'b0, 4'h0);
    for (int k = 1; k <= 10; k++) begin
      n_tests++;
      if (rdy[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready word%0d: rdy=%b, required 1", k, rdy[1]);
      end
      cycle(1'b1, 4'(k));
    end
    cycle(1'b0, 4'h0);
    n_tests++;
    if (cnt[1] !== 16'd10 || lst[1] !== 4'hA) begin
      n_fail++;
      $display("FAIL b2b_result: cnt=%0d last=%h, required cnt=10 last=a", cnt[1], lst[1]);
    end
  endtask

  task automatic test_stall();
    do_reset();
    cycle(1'b0, 4'h0);
    cycle(1'b0, 4'h0);
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b1, 4'h5);
      n_tests++;
      if (rdy[2] !== (k == 3)) begin
        n_fail++;
        $display("FAIL stall_ready after stall %0d: rdy=%b, required %b", k, rdy[2], (k == 3));
      end
    end
    cycle(1'b1, 4'h5);
    n_tests++;
    if (cnt[2] !== 16'd1 || lst[2] !== 4'h5 || rdy[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_xfer: cnt=%0d last=%h rdy=%b, required cnt=1 last=5 rdy=0",
               cnt[2], lst[2], rdy[2]);
    end
    cycle(1'b0, 4'h0);
  endtask

  task automatic test_expect();
    bit seen;
    seen = 0;
    do_reset();
    for (int k = 0; k < 40 && !seen; k++) begin
      cycle(1'b1, 4'($urandom));
      if (cnt[3] == 16'd4) begin
        seen = 1;
        n_tests++;
        if (dn[3] !== 1'b1 || rdy[3] !== 1'b0) begin
          n_fail++;
          $display("FAIL expect_done_edge: done=%b rdy=%b, required done=1 rdy=0", dn[3], rdy[3]);
        end
      end else begin
        n_tests++;
        if (dn[3] !== 1'b0) begin
          n_fail++;
          $display("FAIL expect_early_done: done=%b at cnt=%0d, required 0", dn[3], cnt[3]);
        end
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL expect_reach: cnt=%0d after 40 cycles, required 4", cnt[3]);
    end
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 4'($urandom));
      n_tests++;
      if (cnt[3] !== 16'd4 || dn[3] !== 1'b1 || rdy[3] !== 1'b0) begin
        n_fail++;
        $display("FAIL expect_frozen cycle%0d: cnt=%0d done=%b rdy=%b, required 4/1/0",
                 k, cnt[3], dn[3], rdy[3]);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (100) cycle(1'b1, 4'($urandom));
    n_tests++;
    if (cnt[4] !== 16'd7) begin
      n_fail++;
      $display("FAIL saturate: cnt=%0d, required 7", cnt[4]);
    end
  endtask

  task automatic test_protocol();
    do_reset();
    cycle(1'b0, 4'h0);
    cycle(1'b0, 4'h0);
    cycle(1'b1, 4'h2);
    cycle(1'b1, 4'h6);
    n_tests++;
    if (er[2] !== CHK) begin
      n_fail++;
      $display("FAIL protocol_err: err=%b, required %b", er[2], CHK);
    end
    repeat (5) cycle(1'b0, 4'h0);
    n_tests++;
    if (er[2] !== CHK) begin
      n_fail++;
      $display("FAIL protocol_sticky: err=%b, required %b", er[2], CHK);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b0, 4'h0);
    cycle(1'b0, 4'h0);
    cycle(1'b1, 4'h7);
    valid = 1'b1;
    d = 4'h9;
    #2;
    rst_n = 1'b0;
    model_reset();
    #2;
    n_tests++;
    if (rdy[1] !== 1'b0 || cnt[1] !== 16'd0 || lst[1] !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: rdy=%b cnt=%0d last=%h, required all 0", rdy[1], cnt[1], lst[1]);
    end
    @(negedge clk);
    n_tests++;
    if (cnt[1] !== 16'd0 || lst[1] !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_mid_edge: cnt=%0d last=%h, required 0", cnt[1], lst[1]);
    end
    valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, 4'($urandom));
      for (int i = 0; i < N; i++) begin
        n_tests++;
        if (rdy[i] !== m_rdy[i] || cnt[i] !== 16'(m_cnt[i]) || lst[i] !== 4'(m_last[i]) ||
            dn[i] !== m_done[i] || er[i] !== m_err[i]) begin
          n_fail++;
          $display("FAIL random inst%0d cyc%0d: rdy=%b cnt=%0d last=%h done=%b err=%b, required rdy=%b cnt=%0d last=%h done=%b err=%b",
                   i, k, rdy[i], cnt[i], lst[i], dn[i], er[i],
                   m_rdy[i], m_cnt[i], 4'(m_last[i]), m_done[i], m_err[i]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_back_to_back();
    test_stall();
    test_expect();
    test_saturate();
    test_protocol();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_stream_sink.md
Name: rv_stream_sink

Overview:
- Synthesizable consumer end of the ready/valid stream protocol.
- Accepts words from any ready/valid transmitter, such as the operand generator or the ALU result port.
- Applies pseudo-random, bounded backpressure, keeps the last accepted word and counts transfers.
- Serves as the standard downstream load in bench and FPGA bring-up builds, replacing a passive always-ready sink.

Parameters:
- WIDTH, 4: data word width.
- CNT_WIDTH, 16: transfer counter width.
- LFSR_SEED, 8'hA5: LFSR reset value; must be nonzero.
- READY_THRESHOLD, 128: o_READY requested when LFSR value >= threshold; 0 = always ready.
- MAX_STALL, 7: maximum consecutive cycles with i_VALID=1 and o_READY=0 before ready is forced; range 1..255.
- EXPECT_COUNT, 0: transfers before entering DONE; 0 = unbounded.

Ports:
- i_CLK, input, 1: clock, rising edge.
- i_RSTn, input, 1: asynchronous active-low reset.
- i_VALID, input, 1: transmitter has a word.
- o_READY, output, 1: sink accepts this cycle; registered.
- i_D, input, WIDTH: data word.
- o_LAST_D, output, WIDTH: last accepted word.
- o_COUNT, output, CNT_WIDTH: number of accepted transfers, saturating.
- o_DONE, output, 1: EXPECT_COUNT reached; sticky.
- o_ERR, output, 1: protocol violation seen; sticky.

Behaviour:
- Reset (async assert, sync release): o_READY=0, o_LAST_D=0, o_COUNT=0, o_DONE=0, o_ERR=0, lfsr=LFSR_SEED, stall_cnt=0, state=WAIT.
- Transfer occurs on a rising edge where i_VALID=1 and o_READY=1. On that edge:
  - o_LAST_D<=i_D.
  - o_COUNT increments; it holds at all-ones and never wraps.
- FSM states:
  - WAIT: exactly one cycle after reset release, o_READY=0. Then go to RUN.
  - RUN: the LFSR advances every cycle. It is an 8-bit Galois LFSR, right shift, XOR mask 8'hB8 applied when the shifted-out bit is 1.
  - RUN ready rule: o_READY<=(lfsr_next >= READY_THRESHOLD) || (stall_cnt_next >= MAX_STALL).
  - DONE: entered on the edge of the transfer that makes o_COUNT==EXPECT_COUNT, only when EXPECT_COUNT!=0. On that same edge o_READY<=0 and o_DONE<=1. DONE is left only by reset.
- stall_cnt:
  - Increments, saturating at 255, on each edge where i_VALID=1 and o_READY=0.
  - Clears on a transfer or when i_VALID=0.
  - Result: any word is accepted within MAX_STALL+1 cycles of valid assertion.
- Latency: o_LAST_D and o_COUNT update on the transfer edge. There is no combinational path from i_VALID to o_READY.
- o_READY may be asserted while i_VALID=0. No transfer occurs and nothing updates.
- Back-to-back transfers are allowed every cycle while the ready rule holds.
- In DONE, i_VALID is ignored (o_READY=0) and o_COUNT is frozen.
- EXPECT_COUNT greater than 2^CNT_WIDTH-1 is illegal. DONE would never be reached.
- Reset mid-transfer: all state returns to reset values immediately. A word offered in the same cycle is not counted.
- READY_THRESHOLD=0: o_READY=1 in every RUN cycle.

Optional Feature:
- Macro: RV_STREAM_SINK_PROTOCOL_CHECK_EN.
- Defined: the sink registers prev_stalled = i_VALID && !o_READY and prev_d = i_D. On any RUN edge where prev_stalled=1 and either i_VALID=0 or i_D!=prev_d, it sets o_ERR<=1; o_ERR stays sticky until reset. In simulation it also prints a $display message with $time.
- Not defined: o_ERR is tied to 0 and no checker registers exist.

Test Plan:
- Reset hold, i_VALID=1, i_D=4'h3 -> o_READY=0, o_COUNT=0, o_LAST_D=0; first o_READY possible on the second edge after release.
- READY_THRESHOLD=0, 10 back-to-back words 1..10 -> o_READY=1 every RUN cycle, o_COUNT=10, o_LAST_D=4'hA.
- READY_THRESHOLD=255, MAX_STALL=3, i_VALID held with i_D=4'h5 -> o_READY rises after exactly 3 stalled cycles, one transfer, o_LAST_D=5.
- EXPECT_COUNT=4, continuous valid -> o_DONE=1 and o_READY=0 on the 4th transfer edge; o_COUNT stays 4 for the next 20 cycles.
- CNT_WIDTH=3, 9 transfers -> o_COUNT saturates at 7.
- Macro defined, stalled i_D changes 4'h2->4'h6 while o_READY=0 -> o_ERR=1 next edge, stays 1; with macro undefined, o_ERR=0.
